// File: rtl/memory_pkg.sv
// Shared types and constants for the dual-port memory with power-on clear.
package memory_pkg;
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
endpackage

// File: rtl/memory_rd_pipe.sv
// Read-return pipeline: carries read data and its valid through READ_LATENCY register stages.
module memory_rd_pipe #(
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);
  localparam int STAGES = READ_LATENCY - 1;

  logic [STAGES:0]                 vld_pipe;
  logic [STAGES:0][DATA_WIDTH-1:0] dat_pipe;

  // Data stages load only behind a valid, so the last stage holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      if (in_valid) dat_pipe[0] <= in_data;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_data  = dat_pipe[STAGES];
endmodule

// File: rtl/memory_dp.sv
// Simple dual-port RAM (one write, one read port) that self-clears after reset
// before accepting requests; configurable read latency and collision policy.
module memory_dp
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  generate
    if (READ_LATENCY != RD_LAT_MIN && READ_LATENCY != RD_LAT_MAX) begin : g_bad_lat
      $error("memory_dp: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_addr, clr_nxt;
  logic                    rd_req;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_nxt;
    end
  end

  // Clear counter parks at the last address rather than wrapping.
  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_addr;
    busy      = 1'b0;
    rd_req    = 1'b0;
    case (state)
      INIT: begin
        busy = 1'b1;
        if (clr_addr == LAST_ADDR) state_nxt = READY;
        else                       clr_nxt   = clr_addr + ADDR_WIDTH'(1);
      end
      READY: rd_req = rd_en;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) mem[clr_addr] <= '0;
      else if (wr_en)    mem[wr_addr]  <= wr_data;
    end
  end

  // Data is captured at the request edge, so later writes never leak into it.
  assign rd_word = (BYPASS != 0 && wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];

  memory_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_req),
    .in_data  (rd_word),
    .out_valid(rd_valid),
    .out_data (rd_data)
  );
endmodule

// File: doc/memory_dp.md
MEMORY_DP -- requirements
Module: memory_dp

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter READ_LATENCY, default 1, legal values 1 or 2, SHALL set the cycles from read request to data; other values SHALL fail elaboration.
REQ-004 Parameter BYPASS, default 1, SHALL select the same-address collision behaviour (1 = new data, 0 = old data).
REQ-005 clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_addr  input  ADDR_WIDTH  write address.
REQ-009 wr_data  input  DATA_WIDTH  write data.
REQ-010 rd_en  input  1  read request.
REQ-011 rd_addr  input  ADDR_WIDTH  read address.
REQ-012 rd_data  output  DATA_WIDTH  read data, registered.
REQ-013 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-014 busy  output  1  high while the array is being cleared; requests are ignored.

Function
REQ-015 The FSM SHALL have two states: INIT and READY.
REQ-016 In INIT, a clear counter SHALL write 0 to address clr_addr each cycle, starting at 0 and incrementing by 1.
REQ-017 When clr_addr == DEPTH-1 in INIT, the next state SHALL be READY; INIT SHALL therefore last exactly DEPTH cycles.
REQ-018 busy SHALL be 1 exactly when the state is INIT.
REQ-019 In INIT, wr_en and rd_en SHALL be ignored, with no array write and no rd_valid.
REQ-020 In READY, wr_en=1 SHALL write wr_data to wr_addr at that clock edge.
REQ-021 In READY, rd_en=1 at edge N SHALL produce rd_valid=1 and rd_data=mem[rd_addr] at edge N+READ_LATENCY.
REQ-022 Back-to-back reads SHALL be accepted every cycle, giving a full-throughput pipeline with one rd_valid per request, in order.
REQ-023 When rd_valid=0, rd_data SHALL hold its last value.
REQ-024 Same-cycle wr_en and rd_en to the same address with BYPASS=1 SHALL return wr_data.
REQ-025 Same-cycle wr_en and rd_en to the same address with BYPASS=0 SHALL return the pre-write contents.
REQ-026 Reads and writes to different addresses in the same cycle SHALL be independent.
REQ-027 With READY_LATENCY=2, a write in the cycle after a read to the same address SHALL NOT alter that read's returned data.
REQ-028 The address counter SHALL NOT wrap. It SHALL stop at DEPTH-1 on the INIT-to-READY transition.

Reset
REQ-029 While rst=1, the state SHALL be INIT with clr_addr=0, rd_valid=0, rd_data=0, busy=1, and all in-flight reads discarded.
REQ-030 rst asserted mid-operation, in either state, SHALL abort the current activity and restart the full DEPTH-cycle clear after rst deasserts.
REQ-031 The first clear write (address 0) SHALL occur on the first edge with rst=0.

Structure
REQ-032 Package memory_pkg SHALL hold the state enum typedef (INIT, READY) and the legal READ_LATENCY constants.
REQ-033 The read latency stage SHALL be a sub-module, memory_rd_pipe, parametrised by DATA_WIDTH and READ_LATENCY and carrying data and valid.
REQ-034 The array SHALL be a single unpacked logic array of DEPTH x DATA_WIDTH, with no delays in RTL.

Verification
REQ-035 Reset, then idle -> busy=1 for 32 cycles (ADDR_WIDTH=5), then 0; rd_valid stays 0 throughout.
REQ-036 After INIT, read all 32 addresses back-to-back -> 32 rd_valid pulses, all data 8'h00.
REQ-037 Write 8'hA5 to 3, then read 3 with READ_LATENCY=2 -> rd_valid and 8'hA5 exactly 2 cycles after rd_en.
REQ-038 Same-cycle write 8'h3C and read, both to address 7 (old value 8'h11) -> 8'h3C with BYPASS=1; 8'h11 with BYPASS=0.
REQ-039 Write or read during INIT (wr_en to addr 4 with 8'hFF at cycle 10) -> after READY, addr 4 reads 8'h00; no rd_valid during INIT.
REQ-040 Assert rst 1 cycle in READY with a read in flight -> that rd_valid is suppressed, busy rises, 32-cycle clear repeats, prior data reads 8'h00.
